// File: rtl/remote_controller_pkg.sv
// Shared types and frame layout for the IR remote-control frame decoder.
package remote_pkg;

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned ADDR_LSB   = 0;
  localparam int unsigned ADDRN_LSB  = 8;
  localparam int unsigned CMD_LSB    = 16;
  localparam int unsigned CMDN_LSB   = 24;

  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] f,
                                            input int unsigned lsb);
    return f[lsb +: 8];
  endfunction

endpackage

// File: rtl/remote_controller_if.sv
// Serial line in, decoded key and ready strobe out.
interface remote_controller_if;
  logic       serial;
  logic [7:0] tecla;
  logic       ready;

  modport master (output serial, input tecla, input ready);
  modport slave  (input serial, output tecla, output ready);
endinterface

// File: rtl/remote_controller_ir_sync.sv
// Multi-stage synchronizer for the asynchronous, idle-high IR line.
module ir_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/remote_controller.sv
// NEC-style IR frame decoder: start, 32 payload bits LSB first, stop; emits cmd byte.
// Optional REMOTE_ADDR_CHECK_EN also requires a matching, complemented address byte.
module remote_controller
  import remote_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEV_ADDR    = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  remote_controller_if.slave  bus
);
  logic                  s;
  state_t                state_q, state_d;
  logic [5:0]            cnt_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [7:0]            tecla_q;
  logic                  ready_q;
  logic [7:0]            addr, addr_n, cmd, cmd_n;
  logic                  cmd_ok, addr_ok, frame_ok, load_key;

  ir_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.serial),
    .q   (s)
  );

  assign addr    = frame_byte(frame_q, ADDR_LSB);
  assign addr_n  = frame_byte(frame_q, ADDRN_LSB);
  assign cmd     = frame_byte(frame_q, CMD_LSB);
  assign cmd_n   = frame_byte(frame_q, CMDN_LSB);
  assign cmd_ok  = (cmd == ~cmd_n);
  assign addr_ok = (addr == ~addr_n) && (addr == DEV_ADDR);

`ifdef REMOTE_ADDR_CHECK_EN
  assign frame_ok = cmd_ok && addr_ok;
`else
  logic unused_addr_ok;
  assign unused_addr_ok = addr_ok;
  assign frame_ok       = cmd_ok;
`endif

  always_comb begin
    state_d  = state_q;
    load_key = 1'b0;
    case (state_q)
      IDLE: if (!s) state_d = DATA;
      DATA: if (cnt_q == 6'(FRAME_BITS - 1)) state_d = STOP;
      STOP: begin
        state_d  = IDLE;
        load_key = s && frame_ok;
      end
      default: state_d = IDLE;
    endcase
  end

  // Right shift with s entering at the top: after 32 bits the first payload bit sits at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      tecla_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= load_key;
      if (load_key) tecla_q <= cmd;
      case (state_q)
        IDLE: cnt_q <= '0;
        DATA: begin
          frame_q <= {s, frame_q[FRAME_BITS-1:1]};
          cnt_q   <= cnt_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.tecla = tecla_q;
  assign bus.ready = ready_q;
endmodule

// File: tb/tb_remote_controller.sv
// Scoreboard bench for remote_controller: directed frames, monitor checks each ready pulse.
module tb_remote_controller;
  localparam int unsigned SYNC = 2;

  typedef struct {
    logic [7:0]  key;
    int unsigned at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned edges    = 0;
  exp_t        expq[$];
  logic [7:0]  last_key = 8'h00;
  logic        ready_prev = 1'b0;

  remote_controller_if bus ();

  remote_controller #(.SYNC_STAGES(SYNC), .DEV_ADDR(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected key, at the expected edge.
  always @(negedge clk) begin
    if (bus.ready === 1'b1) begin
      check("ready_single_cycle", {31'd0, ready_prev}, 32'd0);
      if (expq.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("tecla_on_ready", {24'd0, bus.tecla}, {24'd0, e.key});
        check("ready_latency_edge", edges, e.at);
      end
    end
    ready_prev = (bus.ready === 1'b1);
  end

  task automatic send_bit(input logic b);
    bus.serial = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] an,
                            input logic [7:0] c, input logic [7:0] cn,
                            input logic stop, input logic good);
    logic [31:0] w;
    w = {cn, c, an, a};
    send_bit(1'b0);
    for (int unsigned i = 0; i < 32; i++) send_bit(w[i]);
    send_bit(stop);
    if (good) begin
      expq.push_back('{key: c, at: edges + SYNC});
      last_key = c;
    end
  endtask

  task automatic check_hold(input string name);
    check(name, {24'd0, bus.tecla}, {24'd0, last_key});
  endtask

  initial begin
    logic [31:0] w;
    rst        = 1'b1;
    bus.serial = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset_tecla", {24'd0, bus.tecla}, 32'h00);
      check("reset_ready", {31'd0, bus.ready}, 32'd0);
    end
    rst = 1'b0;
    idle(3);

    // Valid frame
    send_frame(8'h00, 8'hFF, 8'h0C, 8'hF3, 1'b1, 1'b1);
    idle(6);
    check_hold("tecla_held_0c");

    // Bad complement: discarded
    send_frame(8'h00, 8'hFF, 8'h0C, 8'h00, 1'b1, 1'b0);
    idle(6);
    check_hold("tecla_after_bad_cmp");

    // Back-to-back, no idle gap
    send_frame(8'h00, 8'hFF, 8'h18, 8'hE7, 1'b1, 1'b1);
    send_frame(8'h00, 8'hFF, 8'h5E, 8'hA1, 1'b1, 1'b1);
    idle(6);
    check_hold("tecla_after_b2b");

    // Stop bit 0: discarded
    send_frame(8'h00, 8'hFF, 8'h33, 8'hCC, 1'b0, 1'b0);
    idle(6);
    check_hold("tecla_after_bad_stop");

    // Identical repeated frames each pulse
    send_frame(8'h00, 8'hFF, 8'h42, 8'hBD, 1'b1, 1'b1);
    send_frame(8'h00, 8'hFF, 8'h42, 8'hBD, 1'b1, 1'b1);
    idle(6);
    check_hold("tecla_after_repeat");

    // Mid-frame reset at payload bit 20
    w = {8'hF3, 8'h0C, 8'hFF, 8'h00};
    send_bit(1'b0);
    for (int unsigned i = 0; i < 19; i++) send_bit(w[i]);
    rst = 1'b1;
    send_bit(w[19]);
    bus.serial = 1'b1;
    @(posedge clk); #1;
    last_key = 8'h00;
    check_hold("tecla_after_midframe_rst");
    check("ready_during_rst", {31'd0, bus.ready}, 32'd0);
    rst = 1'b0;
    idle(2);
    send_frame(8'h00, 8'hFF, 8'h0C, 8'hF3, 1'b1, 1'b1);
    idle(6);
    check_hold("tecla_after_rst_recover");

    // Address handling
`ifdef REMOTE_ADDR_CHECK_EN
    send_frame(8'h01, 8'hFE, 8'h21, 8'hDE, 1'b1, 1'b0);
`else
    send_frame(8'h01, 8'hFE, 8'h21, 8'hDE, 1'b1, 1'b1);
`endif
    idle(6);
    check_hold("tecla_after_addr01");
    send_frame(8'h00, 8'hFF, 8'h37, 8'hC8, 1'b1, 1'b1);
    idle(6);
    check_hold("tecla_after_addr00");

    // Line held low: all-zero frames fail the complement check
    bus.serial = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    check_hold("tecla_line_low");
    rst = 1'b1;
    bus.serial = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_key = 8'h00;
    check_hold("tecla_after_low_rst");

    send_frame(8'h00, 8'hFF, 8'hA5, 8'h5A, 1'b1, 1'b1);
    idle(10);
    check_hold("tecla_final");
    check("scoreboard_drained", expq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
